// File: rtl/ysyx_22040632_tag_array_assoc_if.sv
// ysyx_22040632_tag_array_assoc_if: lookup, fill and flush signals of the tag store
//   master: drives lookup (lookup_valid/addr_index/addr_tag), fill (fill_*) and flush_req,
//           and receives hit/hit_way/victim_way/flush_busy/flush_done
//   slave : the tag store side of the same signals
interface ysyx_22040632_tag_array_assoc_if #(
  parameter int TAG_W = 21,
  parameter int IDX_W = 5,
  parameter int WAYS  = 2
);
  localparam int WAY_W = $clog2(WAYS);
  logic             lookup_valid;
  logic [IDX_W-1:0] addr_index;
  logic [TAG_W-1:0] addr_tag;
  logic             hit;
  logic [WAYS-1:0]  hit_way;
  logic [WAY_W-1:0] victim_way;
  logic             fill_valid;
  logic [IDX_W-1:0] fill_index;
  logic [WAY_W-1:0] fill_way;
  logic [TAG_W-1:0] fill_tag;
  logic             flush_req;
  logic             flush_busy;
  logic             flush_done;
  modport master (
    output lookup_valid, addr_index, addr_tag, fill_valid, fill_index, fill_way, fill_tag, flush_req,
    input  hit, hit_way, victim_way, flush_busy, flush_done
  );
  modport slave (
    input  lookup_valid, addr_index, addr_tag, fill_valid, fill_index, fill_way, fill_tag, flush_req,
    output hit, hit_way, victim_way, flush_busy, flush_done
  );
endinterface

// File: rtl/ysyx_22040632_tag_array_assoc.sv
// ysyx_22040632_tag_array_assoc: N-way set-associative tag store with tree-PLRU and walking flush
//   clk    : clock, all state updates on the rising edge
//   rrst_n : asynchronous active-low reset
//   bus    : slave side of the lookup / fill / flush interface
module ysyx_22040632_tag_array_assoc #(
  parameter int TAG_W = 21,
  parameter int IDX_W = 5,
  parameter int WAYS  = 2
) (
  input logic clk,
  input logic rrst_n,
  ysyx_22040632_tag_array_assoc_if.slave bus
);
  localparam int WAY_W = $clog2(WAYS);
  localparam int SETS  = 1 << IDX_W;
  typedef enum logic {IDLE, FLUSH} state_t;
  state_t           st;
  logic [IDX_W-1:0] cnt;
  logic             busy;
  logic             done;
  logic [WAYS-1:0]  valid [SETS];
  logic [WAYS-1:1]  plru  [SETS];
  logic [TAG_W-1:0] tags  [SETS][WAYS];
  logic [WAY_W-1:0] hidx;
  logic [WAY_W-1:0] vic;
  logic [WAY_W:0]   n;
  // Point every node on the path to way w away from w; nodes are walked root first.
  function automatic logic [WAYS-1:1] upd(input logic [WAYS-1:1] p, input logic [WAY_W-1:0] w);
    logic [WAY_W:0]   k;
    logic [WAY_W-1:0] s;
    k = (WAY_W+1)'(1);
    s = w;
    upd = p;
    for (int l = 0; l < WAY_W; l++) begin
      upd[k[WAY_W-1:0]] = ~s[WAY_W-1];
      k = {k[WAY_W-1:0], s[WAY_W-1]};
      s = s << 1;
    end
  endfunction
  always_comb begin
    for (int w = 0; w < WAYS; w++)
      bus.hit_way[w] = !busy && valid[bus.addr_index][w] && tags[bus.addr_index][w] == bus.addr_tag;
  end
  assign bus.hit        = |bus.hit_way;
  assign bus.victim_way = vic;
  assign bus.flush_busy = busy;
  assign bus.flush_done = done;
  always_comb begin
    hidx = '0;
    for (int w = 0; w < WAYS; w++) hidx = bus.hit_way[w] ? hidx | WAY_W'(w) : hidx;
  end
  // Heap walk: n ends as WAYS + way, so its low bits are the PLRU victim; an invalid way overrides.
  always_comb begin
    n = (WAY_W+1)'(1);
    for (int l = 0; l < WAY_W; l++) n = {n[WAY_W-1:0], plru[bus.addr_index][n[WAY_W-1:0]]};
    vic = n[WAY_W-1:0];
    for (int w = WAYS-1; w >= 0; w--) vic = valid[bus.addr_index][w] ? vic : WAY_W'(w);
  end
  always_ff @(posedge clk or negedge rrst_n) begin
    if (!rrst_n) begin
      st   <= IDLE;
      cnt  <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (st == IDLE) begin
        if (bus.flush_req) begin
          st   <= FLUSH;
          cnt  <= '0;
          busy <= 1'b1;
        end
      end else begin
        cnt <= cnt + 1'b1;
        if (&cnt) begin
          st   <= IDLE;
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end
  // The fill update is written last so it overrides a same-set lookup update.
  always_ff @(posedge clk or negedge rrst_n) begin
    if (!rrst_n) begin
      for (int i = 0; i < SETS; i++) begin
        valid[i] <= '0;
        plru[i]  <= '0;
      end
    end else if (busy) begin
      valid[cnt] <= '0;
      plru[cnt]  <= '0;
    end else begin
      if (bus.lookup_valid && bus.hit) plru[bus.addr_index] <= upd(plru[bus.addr_index], hidx);
      if (bus.fill_valid) begin
        valid[bus.fill_index][bus.fill_way] <= 1'b1;
        plru[bus.fill_index] <= upd(plru[bus.fill_index], bus.fill_way);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (bus.fill_valid && !busy) tags[bus.fill_index][bus.fill_way] <= bus.fill_tag;
  end
endmodule

// File: tb/tb_ysyx_22040632_tag_array_assoc.sv
// tb_ysyx_22040632_tag_array_assoc: directed checks of the 4-way, 32-set tag store
module tb_ysyx_22040632_tag_array_assoc;
  logic clk = 1'b0;
  logic rrst_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;
  int   nb;
  int   nd;
  always #5 clk = ~clk;
  ysyx_22040632_tag_array_assoc_if #(.TAG_W(21), .IDX_W(5), .WAYS(4)) bus ();
  ysyx_22040632_tag_array_assoc #(.TAG_W(21), .IDX_W(5), .WAYS(4)) dut (
    .clk(clk),
    .rrst_n(rrst_n),
    .bus(bus.slave)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic at(input logic [4:0] idx, input logic [20:0] tag);
    bus.addr_index = idx;
    bus.addr_tag   = tag;
    #1;
  endtask
  task automatic fill(input logic [4:0] idx, input logic [1:0] way, input logic [20:0] tag);
    bus.fill_valid = 1'b1;
    bus.fill_index = idx;
    bus.fill_way   = way;
    bus.fill_tag   = tag;
    tick;
    bus.fill_valid = 1'b0;
  endtask
  task automatic hitcyc(input logic [4:0] idx, input logic [20:0] tag);
    bus.lookup_valid = 1'b1;
    at(idx, tag);
    tick;
    bus.lookup_valid = 1'b0;
  endtask
  initial begin
    bus.lookup_valid = 1'b0;
    bus.addr_index   = '0;
    bus.addr_tag     = '0;
    bus.fill_valid   = 1'b0;
    bus.fill_index   = '0;
    bus.fill_way     = '0;
    bus.fill_tag     = '0;
    bus.flush_req    = 1'b0;
    tick;
    tick;
    rrst_n = 1'b1;
    tick;
    at(0, 0);
    chk("rst_hit0", bus.hit, 0);
    chk("rst_vic0", bus.victim_way, 0);
    chk("rst_busy", bus.flush_busy, 0);
    chk("rst_done", bus.flush_done, 0);
    at(31, 21'h100);
    chk("rst_hitway31", bus.hit_way, 0);
    tick;
    bus.fill_valid = 1'b1;
    bus.fill_index = 3;
    bus.fill_way   = 0;
    bus.fill_tag   = 21'h100;
    at(3, 21'h100);
    chk("fill_same_cycle", bus.hit, 0);
    tick;
    bus.fill_valid = 1'b0;
    at(3, 21'h100);
    chk("fill_next_cycle", bus.hit, 1);
    fill(3, 1, 21'h101);
    fill(3, 2, 21'h102);
    fill(3, 3, 21'h103);
    at(3, 21'h102);
    chk("hit_102", bus.hit, 1);
    chk("hitway_102", bus.hit_way, 4'b0100);
    at(3, 21'h104);
    chk("miss_104", bus.hit, 0);
    chk("vic_full", bus.victim_way, 0);
    hitcyc(3, 21'h100);
    at(3, 0);
    chk("plru_w0", bus.victim_way, 2);
    hitcyc(3, 21'h102);
    at(3, 0);
    chk("plru_w2", bus.victim_way, 1);
    hitcyc(3, 21'h101);
    at(3, 0);
    chk("plru_w1", bus.victim_way, 3);
    fill(7, 1, 21'h200);
    at(7, 21'h200);
    chk("s7_hitway", bus.hit_way, 4'b0010);
    chk("s7_vic0", bus.victim_way, 0);
    fill(7, 0, 21'h201);
    at(7, 0);
    chk("s7_vic2", bus.victim_way, 2);
    hitcyc(3, 21'h103);
    at(3, 0);
    chk("plru_w3", bus.victim_way, 0);
    hitcyc(3, 21'h100);
    at(3, 0);
    chk("conf_pre", bus.victim_way, 2);
    bus.lookup_valid = 1'b1;
    bus.fill_valid   = 1'b1;
    bus.fill_index   = 3;
    bus.fill_way     = 0;
    bus.fill_tag     = 21'h100;
    at(3, 21'h102);
    chk("conf_hitway", bus.hit_way, 4'b0100);
    tick;
    bus.lookup_valid = 1'b0;
    bus.fill_valid   = 1'b0;
    at(3, 0);
    chk("conf_fill_wins", bus.victim_way, 2);
    fill(0, 0, 21'h300);
    fill(15, 1, 21'h301);
    fill(31, 2, 21'h302);
    at(15, 21'h301);
    chk("pre_flush_hit", bus.hit, 1);
    bus.flush_req = 1'b1;
    tick;
    bus.flush_req = 1'b0;
    nb = 0;
    while (bus.flush_busy && nb < 40) begin
      nb++;
      if (nb == 2) begin
        at(31, 21'h302);
        chk("busy_hit_forced", bus.hit, 0);
      end
      if (nb == 20) begin
        bus.fill_valid = 1'b1;
        bus.fill_index = 3;
        bus.fill_way   = 1;
        bus.fill_tag   = 21'h3ff;
      end
      tick;
      bus.fill_valid = 1'b0;
    end
    chk("busy_cycles", nb, 32);
    chk("done_pulse", bus.flush_done, 1);
    tick;
    chk("done_one", bus.flush_done, 0);
    at(0, 21'h300);
    chk("flush_miss0", bus.hit, 0);
    at(15, 21'h301);
    chk("flush_miss15", bus.hit, 0);
    at(31, 21'h302);
    chk("flush_miss31", bus.hit, 0);
    tick;
    at(3, 21'h3ff);
    chk("busy_fill_drop", bus.hit, 0);
    at(3, 21'h100);
    chk("flush_miss3", bus.hit, 0);
    chk("flush_vic3", bus.victim_way, 0);
    tick;
    fill(0, 0, 21'h300);
    fill(31, 2, 21'h302);
    bus.flush_req = 1'b1;
    tick;
    bus.flush_req = 1'b0;
    nb = 0;
    while (bus.flush_busy && nb < 10) begin
      nb++;
      if (nb < 10) tick;
    end
    chk("rst_mid_cycles", nb, 10);
    rrst_n = 1'b0;
    #1;
    chk("rst_mid_busy", bus.flush_busy, 0);
    tick;
    rrst_n = 1'b1;
    nd = 0;
    for (int i = 0; i < 40; i++) begin
      nd += bus.flush_done ? 1 : 0;
      tick;
    end
    chk("rst_mid_nodone", nd, 0);
    at(31, 21'h302);
    chk("rst_mid_miss31", bus.hit, 0);
    at(0, 21'h300);
    chk("rst_mid_miss0", bus.hit, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
